// File: rtl/aclk_lcd_scan_driver_if.sv
// LCD character stream between the alarm-clock scan driver and the display.
// Latency: none; plain signal bundle.
// Backpressure: the display holds lcd_ready low to stall the current character.
interface aclk_lcd_scan_driver_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
);
  logic [7:0]    lcd_data;
  logic [DW-1:0] lcd_digit_sel;
  logic          lcd_valid;
  logic          lcd_ready;
  logic          frame_done;

  modport master (
    output lcd_data,
    output lcd_digit_sel,
    output lcd_valid,
    output frame_done,
    input  lcd_ready
  );

  modport slave (
    input  lcd_data,
    input  lcd_digit_sel,
    input  lcd_valid,
    input  frame_done,
    output lcd_ready
  );
endinterface

// File: rtl/aclk_lcd_scan_driver.sv
// Alarm-clock display scanner (MSD-first ASCII digits) plus alarm sounder.
// Latency: first digit valid one cycle after refresh; sound_alarm one cycle after match edge.
// Backpressure: lcd_ready low holds the current digit; refreshes during a frame collapse into one pending frame.
module aclk_lcd_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int ALARM_LEN  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] key,
  input  logic [4*NUM_DIGITS-1:0] alarm_time,
  input  logic [4*NUM_DIGITS-1:0] current_time,
  input  logic                    show_new_time,
  input  logic                    show_alarm,
  input  logic                    refresh,
  input  logic                    stop_alarm,
  output logic                    sound_alarm,
  aclk_lcd_scan_driver_if.master  lcd
);

  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TW = 4 * NUM_DIGITS;
  localparam logic [DW-1:0] MSD = DW'(NUM_DIGITS - 1);
  localparam logic [15:0]   LEN = 16'(ALARM_LEN);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] snap_q, snap_d;
  logic          pending_q, pending_d;
  logic [7:0]    data_q, data_d;
  logic [DW-1:0] sel_q, sel_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic [TW-1:0] src;

  logic          match, match_q, rise;
  logic [15:0]   cnt_q;

  function automatic logic [7:0] decode(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h3A;
  endfunction

  function automatic logic [3:0] digit_of(input logic [TW-1:0] v, input logic [DW-1:0] i);
    logic [TW-1:0] sh;
    sh = v >> {i, 2'b00};
    return sh[3:0];
  endfunction

  // Display source priority: new key entry, then alarm setting, then running time.
  always_comb begin
    src = show_new_time ? key : (show_alarm ? alarm_time : current_time);
  end

  // Display FSM: next state and next registered output values.
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    pending_d = pending_q;
    data_d    = data_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (refresh || pending_q) begin
          snap_d    = src;
          pending_d = 1'b0;
          state_d   = SEND;
          valid_d   = 1'b1;
          sel_d     = MSD;
          data_d    = decode(digit_of(src, MSD));
        end
      end
      SEND: begin
        if (refresh) pending_d = 1'b1;
        if (valid_q && lcd.lcd_ready) begin
          if (sel_q == '0) begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            sel_d  = sel_q - 1'b1;
            data_d = decode(digit_of(snap_q, sel_q - 1'b1));
          end
        end
      end
      DONE: begin
        if (refresh) pending_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Display FSM state and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      pending_q <= 1'b0;
      data_q    <= 8'h00;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      pending_q <= pending_d;
      data_q    <= data_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign lcd.lcd_data      = data_q;
  assign lcd.lcd_digit_sel = sel_q;
  assign lcd.lcd_valid     = valid_q;
  assign lcd.frame_done    = done_q;

  assign match = (current_time == alarm_time);
  assign rise  = match && !match_q;

  // Alarm sounder: edge-triggered, stop wins over a coincident trigger, re-edge reloads.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      match_q     <= 1'b0;
      sound_alarm <= 1'b0;
      cnt_q       <= 16'd0;
    end else begin
      match_q <= match;
      if (stop_alarm) begin
        sound_alarm <= 1'b0;
        cnt_q       <= 16'd0;
      end else if (rise) begin
        sound_alarm <= 1'b1;
        cnt_q       <= LEN;
      end else if (sound_alarm) begin
        cnt_q <= cnt_q - 16'd1;
        if (cnt_q == 16'd1) sound_alarm <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aclk_lcd_scan_driver.sv
// Bench for the alarm-clock LCD scan driver: table vectors, random frames, alarm model.
// Latency: lock-step, outputs sampled 1 time unit after each rising edge.
// Backpressure: lcd_ready stalls are driven from the stimulus.
module tb_aclk_lcd_scan_driver;

  localparam int L = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] key = '0, alm = 16'hFFFF, cur = '0;
  logic        sn = 1'b0, sa = 1'b0, refresh = 1'b0, stop = 1'b0;
  logic        sound;

  int n_vec = 0;
  int n_err = 0;

  aclk_lcd_scan_driver_if #(.NUM_DIGITS(4)) lcd_if ();

  aclk_lcd_scan_driver #(.NUM_DIGITS(4), .ALARM_LEN(L)) dut (
    .clock         (clk),
    .reset         (rst_n),
    .key           (key),
    .alarm_time    (alm),
    .current_time  (cur),
    .show_new_time (sn),
    .show_alarm    (sa),
    .refresh       (refresh),
    .stop_alarm    (stop),
    .sound_alarm   (sound),
    .lcd           (lcd_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sn;
    logic        sa;
    logic [15:0] k;
    logic [15:0] a;
    logic [15:0] c;
    int          stall;
    logic        scr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected ASCII for each digit of a 4-digit BCD word, digit i in byte i.
  function automatic logic [31:0] model_frame(input logic [15:0] src);
    logic [31:0] r;
    int d;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      d = int'((src >> (4 * i)) & 16'hF);
      r[8*i +: 8] = (d < 10) ? 8'(48 + d) : 8'd58;
    end
    return r;
  endfunction

  task automatic scramble();
    key = 16'($urandom);
    alm = 16'($urandom);
    cur = 16'($urandom);
    sn  = 1'($urandom);
    sa  = 1'($urandom);
  endtask

  task automatic run_frame(input string nm, input logic [31:0] exp, input int stall_first,
                           input bit rnd_stall, input bit scr);
    refresh = 1'b1;
    step();
    refresh = 1'b0;
    if (scr) scramble();
    for (int d = 3; d >= 0; d--) begin
      int ns;
      ns = (d == 3) ? stall_first : (rnd_stall ? int'($urandom_range(0, 2)) : 0);
      for (int s = 0; s <= ns; s++) begin
        lcd_if.lcd_ready = (s == ns);
        chk({nm, "_valid"}, 32'(lcd_if.lcd_valid), 32'd1);
        chk({nm, "_sel"}, 32'(lcd_if.lcd_digit_sel), 32'(d));
        chk({nm, "_data"}, 32'(lcd_if.lcd_data), 32'(exp[8*d +: 8]));
        step();
        if (scr) scramble();
      end
    end
    lcd_if.lcd_ready = 1'b1;
    chk({nm, "_done_v"}, 32'(lcd_if.lcd_valid), 32'd0);
    chk({nm, "_done"}, 32'(lcd_if.frame_done), 32'd1);
    step();
    chk({nm, "_done_1cyc"}, 32'(lcd_if.frame_done), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_data"}, 32'(lcd_if.lcd_data), 32'd0);
    chk({nm, "_sel"}, 32'(lcd_if.lcd_digit_sel), 32'd0);
    chk({nm, "_valid"}, 32'(lcd_if.lcd_valid), 32'd0);
    chk({nm, "_done"}, 32'(lcd_if.frame_done), 32'd0);
    chk({nm, "_sound"}, 32'(sound), 32'd0);
  endtask

  initial begin
    logic [15:0] src;
    int          hi;
    int          rem;
    logic        pm, m;

    lcd_if.lcd_ready = 1'b1;
    tbl[0] = '{1'b0, 1'b0, 16'h0000, 16'hFFFF, 16'h1234, 0, 1'b0, 32'h31323334};
    tbl[1] = '{1'b1, 1'b0, 16'h9A05, 16'hFFFF, 16'h1234, 3, 1'b1, 32'h393A3035};
    tbl[2] = '{1'b0, 1'b1, 16'h1111, 16'h0789, 16'h2222, 0, 1'b0, 32'h30373839};
    tbl[3] = '{1'b1, 1'b1, 16'hFBC0, 16'h5555, 16'h6666, 1, 1'b0, 32'h3A3A3A30};
    tbl[4] = '{1'b0, 1'b0, 16'h4444, 16'hE999, 16'h5678, 2, 1'b1, 32'h35363738};

    // Reset state
    step();
    step();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    step();
    chk_reset_outputs("rst_rel");

    // Table vectors
    for (int i = 0; i < 5; i++) begin
      sn = tbl[i].sn; sa = tbl[i].sa; key = tbl[i].k; alm = tbl[i].a; cur = tbl[i].c;
      step();
      run_frame($sformatf("tbl%0d", i), tbl[i].exp, tbl[i].stall, 1'b0, tbl[i].scr);
    end

    // Random frames, sources scrambled mid-frame
    for (int i = 0; i < 15; i++) begin
      scramble();
      src = sn ? key : (sa ? alm : cur);
      run_frame("rnd", model_frame(src), int'($urandom_range(0, 3)), 1'b1, 1'b1);
    end

    // Two refreshes during SEND collapse into one extra frame two cycles after frame_done
    sn = 1'b0; sa = 1'b0; cur = 16'h1234; alm = 16'hFFFF; lcd_if.lcd_ready = 1'b1;
    step();
    refresh = 1'b1;
    step();
    chk("dbl_sel3", 32'(lcd_if.lcd_digit_sel), 32'd3);
    step();
    chk("dbl_sel2", 32'(lcd_if.lcd_digit_sel), 32'd2);
    refresh = 1'b0;
    step();
    chk("dbl_sel1", 32'(lcd_if.lcd_digit_sel), 32'd1);
    step();
    chk("dbl_sel0", 32'(lcd_if.lcd_digit_sel), 32'd0);
    step();
    chk("dbl_done", 32'(lcd_if.frame_done), 32'd1);
    step();
    chk("dbl_gap_v", 32'(lcd_if.lcd_valid), 32'd0);
    chk("dbl_gap_d", 32'(lcd_if.frame_done), 32'd0);
    step();
    for (int d = 3; d >= 0; d--) begin
      chk("dbl2_valid", 32'(lcd_if.lcd_valid), 32'd1);
      chk("dbl2_sel", 32'(lcd_if.lcd_digit_sel), 32'(d));
      chk("dbl2_data", 32'(lcd_if.lcd_data), 32'(8'h31 + 8'(3 - d)));
      step();
    end
    chk("dbl2_done", 32'(lcd_if.frame_done), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("dbl_nomore", 32'({lcd_if.lcd_valid, lcd_if.frame_done}), 32'd0);
    end

    // Reset on the second digit aborts the frame without frame_done
    refresh = 1'b1;
    step();
    refresh = 1'b0;
    chk("ab_sel3", 32'(lcd_if.lcd_digit_sel), 32'd3);
    step();
    chk("ab_sel2", 32'(lcd_if.lcd_digit_sel), 32'd2);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("ab_rst");
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ab_quiet", 32'({lcd_if.lcd_valid, lcd_if.frame_done}), 32'd0);
    end
    run_frame("ab_next", 32'h31323334, 0, 1'b0, 1'b0);

    // Alarm: sustained match sounds exactly L cycles
    alm = 16'h0700; cur = 16'h0659; stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    chk("alm_idle", 32'(sound), 32'd0);
    cur = 16'h0700;
    step();
    chk("alm_rise", 32'(sound), 32'd1);
    hi = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (sound) hi++;
    end
    chk("alm_len", 32'(hi), 32'(L));

    // stop_alarm on the 5th high cycle
    cur = 16'h0000;
    step();
    cur = 16'h0700;
    step();
    step(); step(); step(); step();
    chk("stop_5th", 32'(sound), 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_clr", 32'(sound), 32'd0);
    step();
    chk("stop_noretrig", 32'(sound), 32'd0);

    // stop coinciding with a rising match edge wins
    cur = 16'h0000;
    step();
    cur = 16'h0700; stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_coin", 32'(sound), 32'd0);
    step();
    chk("stop_coin2", 32'(sound), 32'd0);

    // Match held through reset release: first cycle after release is a rising edge
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("rel_c1", 32'(sound), 32'd0);
    step();
    chk("rel_c2", 32'(sound), 32'd1);

    // Random alarm traffic against a remaining-cycles model, display running concurrently
    cur = 16'h0001; stop = 1'b1;
    step();
    stop = 1'b0;
    pm = 1'b0;
    rem = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) cur = ($urandom_range(0, 1) == 0) ? alm : 16'(i);
      stop = ($urandom_range(0, 15) == 0);
      refresh = ($urandom_range(0, 7) == 0);
      lcd_if.lcd_ready = 1'($urandom);
      m = (cur == alm);
      step();
      if (stop) rem = 0;
      else if (m && !pm) rem = L;
      else if (rem > 0) rem--;
      pm = m;
      chk("alm_rand", 32'(sound), 32'(rem > 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
